// File: rtl/triangle_pkg.sv
// Shared screen-space triangle types for the projection, queueing and raster stages.
package triangle_pkg;
   localparam int COORD_W = 10;
   localparam int COORDS  = 6;
   localparam int TRI_W   = COORD_W * COORDS;

   // Packed order: [0]=x0, [1]=y0, [2]=x1, [3]=y1, [4]=x2, [5]=y2
   typedef logic [COORDS-1:0][COORD_W-1:0] triangle_t;
endpackage

// File: rtl/triangle_fifo_mem.sv
// Simple dual-port RAM: one write port, one registered read port.
module triangle_fifo_mem #(
   parameter int  DATA_W = 60,
   parameter int  DEPTH  = 128,
   localparam int AW     = $clog2(DEPTH)
) (
   input  logic              i_clk,
   input  logic              i_rst_n,
   input  logic              i_we,
   input  logic [AW-1:0]     i_waddr,
   input  logic [DATA_W-1:0] i_wdata,
   input  logic              i_re,
   input  logic [AW-1:0]     i_raddr,
   output logic [DATA_W-1:0] o_rdata
);
   logic [DATA_W-1:0] r_mem [DEPTH];
   logic [DATA_W-1:0] r_rdata;

   always_ff @(posedge i_clk) begin
      if (i_we) r_mem[i_waddr] <= i_wdata;
   end

   // Only the output register is reset; the array itself never is.
   always_ff @(posedge i_clk) begin
      if (!i_rst_n)  r_rdata <= '0;
      else if (i_re) r_rdata <= r_mem[i_raddr];
   end

   assign o_rdata = r_rdata;
endmodule

// File: rtl/triangle_fifo.sv
// Triangle queue between projection and raster: registered-read or show-ahead FIFO
// with occupancy count, almost-full threshold, sticky error flags and flush.
module triangle_fifo #(
   parameter int  COORD_W   = triangle_pkg::COORD_W,
   parameter int  COORDS    = triangle_pkg::COORDS,
   parameter int  DEPTH     = 128,
   parameter int  AF_LEVEL  = DEPTH - 4,
   parameter int  SHOWAHEAD = 0,
   localparam int DATA_W    = COORD_W * COORDS,
   localparam int AW        = $clog2(DEPTH)
) (
   input  logic              Clk,
   input  logic              Reset_n,
   input  logic              flush,
   input  logic              w_en,
   input  logic [DATA_W-1:0] data_in,
   output logic              full,
   output logic              almost_full,
   input  logic              r_en,
   output logic [DATA_W-1:0] data_out,
   output logic              data_valid,
   output logic              empty,
   output logic [AW:0]       count,
   output logic              overflow,
   output logic              underflow
);
   localparam logic [AW:0] LP_DEPTH = (AW+1)'(DEPTH);
   localparam logic [AW:0] LP_AF    = (AW+1)'(AF_LEVEL);

   logic [AW-1:0]     r_wr_ptr, r_rd_ptr;
   logic [AW:0]       r_count;
   logic              r_ovf, r_udf, r_dv, r_sel_byp;
   logic [DATA_W-1:0] r_byp;
   logic [DATA_W-1:0] w_rdata;
   logic [AW:0]       w_ram_cnt;
   logic              w_wr_acc, w_rd_acc, w_ram_we, w_ram_re;
   logic              w_load, w_ram_has, w_bypass, w_dv_nxt;

   assign w_wr_acc = w_en && !full;
   assign w_rd_acc = r_en && !empty;

   always_comb begin
      w_ram_cnt = r_count;
      w_load    = 1'b0;
      w_ram_has = 1'b0;
      w_bypass  = 1'b0;
      w_ram_re  = !flush && w_rd_acc;
      w_ram_we  = !flush && w_wr_acc;
      w_dv_nxt  = w_rd_acc;
      if (SHOWAHEAD != 0) begin
         // The head entry sits in the output stage and is part of count.
         w_ram_cnt = r_count - {{AW{1'b0}}, r_dv};
         w_ram_has = (w_ram_cnt != '0);
         w_load    = !r_dv || w_rd_acc;
         w_ram_re  = !flush && w_load && w_ram_has;
         // Nothing in RAM to prefetch: the incoming entry goes straight to the head.
         w_bypass  = w_load && !w_ram_has && w_wr_acc;
         w_ram_we  = !flush && w_wr_acc && !w_bypass;
         w_dv_nxt  = w_load ? (w_ram_has || w_wr_acc) : 1'b1;
      end
   end

   always_ff @(posedge Clk) begin
      if (!Reset_n) begin
         r_wr_ptr  <= '0;
         r_rd_ptr  <= '0;
         r_count   <= '0;
         r_ovf     <= 1'b0;
         r_udf     <= 1'b0;
         r_dv      <= 1'b0;
         r_sel_byp <= 1'b0;
         r_byp     <= '0;
      end else if (flush) begin
         r_wr_ptr  <= '0;
         r_rd_ptr  <= '0;
         r_count   <= '0;
         r_ovf     <= 1'b0;
         r_udf     <= 1'b0;
         r_dv      <= 1'b0;
         r_sel_byp <= 1'b0;
      end else begin
         if (w_ram_we) r_wr_ptr <= r_wr_ptr + 1'b1;
         if (w_ram_re) r_rd_ptr <= r_rd_ptr + 1'b1;
         if (w_wr_acc && !w_rd_acc)      r_count <= r_count + 1'b1;
         else if (w_rd_acc && !w_wr_acc) r_count <= r_count - 1'b1;
         if (w_en && full)  r_ovf <= 1'b1;
         if (r_en && empty) r_udf <= 1'b1;
         r_dv <= w_dv_nxt;
         if (w_bypass) begin
            r_byp     <= data_in;
            r_sel_byp <= 1'b1;
         end else if (w_ram_re) begin
            r_sel_byp <= 1'b0;
         end
      end
   end

   triangle_fifo_mem #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH)
   ) u_mem (
      .i_clk   (Clk),
      .i_rst_n (Reset_n),
      .i_we    (w_ram_we),
      .i_waddr (r_wr_ptr),
      .i_wdata (data_in),
      .i_re    (w_ram_re),
      .i_raddr (r_rd_ptr),
      .o_rdata (w_rdata)
   );

   assign data_out    = r_sel_byp ? r_byp : w_rdata;
   assign data_valid  = r_dv;
   assign count       = r_count;
   assign empty       = (r_count == '0);
   assign full        = (r_count == LP_DEPTH);
   assign almost_full = (r_count >= LP_AF);
   assign overflow    = r_ovf;
   assign underflow   = r_udf;
endmodule

// File: tb/tb_triangle_fifo.sv
// Directed and queue-model checks of triangle_fifo in registered and show-ahead modes.
module tb_triangle_fifo;
   localparam int DW = 60;

   logic          clk = 1'b0;
   logic          rst_n, flush, w_en, r_en;
   logic [DW-1:0] din;
   logic [DW-1:0] dout0, dout1;
   logic          dv0, dv1, empty0, empty1, full0, full1, af0, af1;
   logic          ovf0, ovf1, udf0, udf1;
   logic [3:0]    cnt0, cnt1;
   int            checks = 0;
   int            errors = 0;

   always #5 clk = ~clk;

   triangle_fifo #(.DEPTH(8), .AF_LEVEL(6), .SHOWAHEAD(0)) u_dut0 (
      .Clk(clk), .Reset_n(rst_n), .flush(flush), .w_en(w_en), .data_in(din),
      .full(full0), .almost_full(af0), .r_en(r_en), .data_out(dout0),
      .data_valid(dv0), .empty(empty0), .count(cnt0), .overflow(ovf0), .underflow(udf0));

   triangle_fifo #(.DEPTH(8), .AF_LEVEL(6), .SHOWAHEAD(1)) u_dut1 (
      .Clk(clk), .Reset_n(rst_n), .flush(flush), .w_en(w_en), .data_in(din),
      .full(full1), .almost_full(af1), .r_en(r_en), .data_out(dout1),
      .data_valid(dv1), .empty(empty1), .count(cnt1), .overflow(ovf1), .underflow(udf1));

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      flush = 1'b0; w_en = 1'b0; r_en = 1'b0; din = '0;
   endtask

   task automatic do_flush();
      idle(); flush = 1'b1; tick(); flush = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; idle();
      tick(); tick();
      rst_n = 1'b1;
      checks++; if (dout0 !== '0) begin errors++; $display("FAIL reset_dout0 got %h want 0", dout0); end
      checks++; if (dv0 !== 1'b0) begin errors++; $display("FAIL reset_dv0 got %b want 0", dv0); end
      checks++; if (empty0 !== 1'b1 || full0 !== 1'b0 || af0 !== 1'b0) begin errors++; $display("FAIL reset_flags0 got e%b f%b af%b want e1 f0 af0", empty0, full0, af0); end
      checks++; if (cnt0 !== 4'd0 || ovf0 !== 1'b0 || udf0 !== 1'b0) begin errors++; $display("FAIL reset_cnt0 got c%0d o%b u%b want c0 o0 u0", cnt0, ovf0, udf0); end
      checks++; if (dout1 !== '0 || dv1 !== 1'b0 || empty1 !== 1'b1 || cnt1 !== 4'd0) begin errors++; $display("FAIL reset_dut1 got d%h v%b e%b c%0d want 0 0 1 0", dout1, dv1, empty1, cnt1); end
   endtask

   task automatic test_basic();
      for (int i = 1; i <= 4; i++) begin
         w_en = 1'b1; din = DW'(i); tick();
      end
      idle();
      checks++; if (cnt0 !== 4'd4) begin errors++; $display("FAIL basic_cnt_after_writes got %0d want 4", cnt0); end
      for (int i = 1; i <= 4; i++) begin
         r_en = 1'b1; tick();
         checks++; if (dv0 !== 1'b1 || dout0 !== DW'(i)) begin errors++; $display("FAIL basic_read%0d got v%b d%h want v1 d%h", i, dv0, dout0, DW'(i)); end
         checks++; if (cnt0 !== 4'(4 - i)) begin errors++; $display("FAIL basic_cnt%0d got %0d want %0d", i, cnt0, 4 - i); end
      end
      idle(); tick();
      checks++; if (dv0 !== 1'b0 || dout0 !== DW'(4)) begin errors++; $display("FAIL basic_hold got v%b d%h want v0 d4", dv0, dout0); end
      checks++; if (empty0 !== 1'b1 || udf0 !== 1'b0) begin errors++; $display("FAIL basic_end got e%b u%b want e1 u0", empty0, udf0); end
      checks++; if (empty1 !== 1'b1 || dv1 !== 1'b0) begin errors++; $display("FAIL basic_end1 got e%b v%b want e1 v0", empty1, dv1); end
   endtask

   task automatic test_full();
      do_flush();
      for (int k = 1; k <= 8; k++) begin
         w_en = 1'b1; din = DW'(8'h10 + k - 1); tick();
         checks++; if (af0 !== (k >= 6) || full0 !== (k == 8)) begin errors++; $display("FAIL full_level%0d got af%b f%b want af%b f%b", k, af0, full0, k >= 6, k == 8); end
      end
      din = DW'(8'h99); tick();
      checks++; if (ovf0 !== 1'b1 || cnt0 !== 4'd8) begin errors++; $display("FAIL full_ovf got o%b c%0d want o1 c8", ovf0, cnt0); end
      checks++; if (ovf1 !== 1'b1 || cnt1 !== 4'd8 || dout1 !== DW'(8'h10)) begin errors++; $display("FAIL full_ovf1 got o%b c%0d d%h want o1 c8 d10", ovf1, cnt1, dout1); end
      r_en = 1'b1; din = DW'(8'hEE); tick();
      checks++; if (dv0 !== 1'b1 || dout0 !== DW'(8'h10)) begin errors++; $display("FAIL full_rw_data got v%b d%h want v1 d10", dv0, dout0); end
      checks++; if (cnt0 !== 4'd7 || ovf0 !== 1'b1) begin errors++; $display("FAIL full_rw_cnt got c%0d o%b want c7 o1", cnt0, ovf0); end
      checks++; if (dout1 !== DW'(8'h11) || cnt1 !== 4'd7) begin errors++; $display("FAIL full_rw1 got d%h c%0d want d11 c7", dout1, cnt1); end
      w_en = 1'b0;
      for (int i = 0; i < 7; i++) begin
         tick();
         checks++; if (dout0 !== DW'(8'h11 + i)) begin errors++; $display("FAIL full_readback%0d got %h want %h", i, dout0, DW'(8'h11 + i)); end
      end
      checks++; if (cnt0 !== 4'd0 || empty0 !== 1'b1) begin errors++; $display("FAIL full_drained got c%0d e%b want c0 e1", cnt0, empty0); end
      w_en = 1'b1; r_en = 1'b1; din = DW'(8'h55); tick();
      idle();
      checks++; if (cnt0 !== 4'd1 || udf0 !== 1'b1 || dv0 !== 1'b0) begin errors++; $display("FAIL empty_rw got c%0d u%b v%b want c1 u1 v0", cnt0, udf0, dv0); end
      checks++; if (dv1 !== 1'b1 || dout1 !== DW'(8'h55) || udf1 !== 1'b1) begin errors++; $display("FAIL empty_rw1 got v%b d%h u%b want v1 d55 u1", dv1, dout1, udf1); end
   endtask

   task automatic test_showahead();
      do_flush();
      w_en = 1'b1; din = DW'(8'hA); tick();
      checks++; if (dv1 !== 1'b1 || dout1 !== DW'(8'hA)) begin errors++; $display("FAIL sa_first got v%b d%h want v1 dA", dv1, dout1); end
      din = DW'(8'hB); tick();
      din = DW'(8'hC); tick();
      idle();
      checks++; if (cnt1 !== 4'd3 || dout1 !== DW'(8'hA)) begin errors++; $display("FAIL sa_fill got c%0d d%h want c3 dA", cnt1, dout1); end
      r_en = 1'b1; tick();
      checks++; if (dv1 !== 1'b1 || dout1 !== DW'(8'hB)) begin errors++; $display("FAIL sa_pop1 got v%b d%h want v1 dB", dv1, dout1); end
      tick();
      checks++; if (dv1 !== 1'b1 || dout1 !== DW'(8'hC)) begin errors++; $display("FAIL sa_pop2 got v%b d%h want v1 dC", dv1, dout1); end
      tick();
      checks++; if (empty1 !== 1'b1 || dv1 !== 1'b0) begin errors++; $display("FAIL sa_empty got e%b v%b want e1 v0", empty1, dv1); end
      idle(); w_en = 1'b1; din = DW'(8'hD); tick();
      r_en = 1'b1; din = DW'(8'hE); tick();
      idle();
      checks++; if (dout1 !== DW'(8'hE) || cnt1 !== 4'd1 || dv1 !== 1'b1) begin errors++; $display("FAIL sa_bypass_pop got d%h c%0d v%b want dE c1 v1", dout1, cnt1, dv1); end
   endtask

   task automatic test_flush_reset();
      do_flush();
      for (int k = 0; k < 9; k++) begin
         w_en = 1'b1; din = DW'(8'h20 + k); tick();
      end
      idle(); r_en = 1'b1;
      tick(); tick(); tick();
      idle();
      checks++; if (cnt0 !== 4'd5 || ovf0 !== 1'b1 || dv0 !== 1'b1) begin errors++; $display("FAIL flush_pre got c%0d o%b v%b want c5 o1 v1", cnt0, ovf0, dv0); end
      flush = 1'b1; w_en = 1'b1; din = DW'(8'h77); tick();
      idle();
      checks++; if (cnt0 !== 4'd0 || empty0 !== 1'b1) begin errors++; $display("FAIL flush_cnt got c%0d e%b want c0 e1", cnt0, empty0); end
      checks++; if (ovf0 !== 1'b0 || udf0 !== 1'b0 || dv0 !== 1'b0) begin errors++; $display("FAIL flush_flags got o%b u%b v%b want 0 0 0", ovf0, udf0, dv0); end
      checks++; if (cnt1 !== 4'd0 || dv1 !== 1'b0 || ovf1 !== 1'b0) begin errors++; $display("FAIL flush_dut1 got c%0d v%b o%b want 0 0 0", cnt1, dv1, ovf1); end
      tick();
      checks++; if (cnt0 !== 4'd0 || empty1 !== 1'b1) begin errors++; $display("FAIL flush_write_ignored got c%0d e1=%b want c0 e1", cnt0, empty1); end
      w_en = 1'b1;
      for (int k = 0; k < 3; k++) begin
         din = DW'(8'h31 + k); tick();
      end
      r_en = 1'b1; din = DW'(8'h34); tick();
      checks++; if (dout0 !== DW'(8'h31) || dv0 !== 1'b1) begin errors++; $display("FAIL burst_pre got d%h v%b want d31 v1", dout0, dv0); end
      rst_n = 1'b0; din = DW'(8'h35); tick();
      checks++; if (dout0 !== '0 || dv0 !== 1'b0 || cnt0 !== 4'd0) begin errors++; $display("FAIL midreset0 got d%h v%b c%0d want 0 0 0", dout0, dv0, cnt0); end
      checks++; if (empty0 !== 1'b1 || full0 !== 1'b0 || af0 !== 1'b0 || ovf0 !== 1'b0 || udf0 !== 1'b0) begin errors++; $display("FAIL midreset_flags0 got e%b f%b af%b o%b u%b want 1 0 0 0 0", empty0, full0, af0, ovf0, udf0); end
      checks++; if (dout1 !== '0 || dv1 !== 1'b0 || cnt1 !== 4'd0 || empty1 !== 1'b1) begin errors++; $display("FAIL midreset1 got d%h v%b c%0d e%b want 0 0 0 1", dout1, dv1, cnt1, empty1); end
      rst_n = 1'b1; idle(); tick();
   endtask

   task automatic test_random();
      logic [DW-1:0] q[$];
      logic [DW-1:0] exp_rd;
      logic [63:0]   rnd;
      logic          we, re, wacc, racc;
      int            wpct;
      do_flush();
      q.delete();
      for (int c = 0; c < 1000; c++) begin
         wpct = ((c / 100) % 2 == 0) ? 70 : 30;
         we   = ($urandom_range(0, 99) < wpct);
         re   = ($urandom_range(0, 99) < (100 - wpct));
         rnd  = {$urandom, $urandom};
         wacc = we && (q.size() < 8);
         racc = re && (q.size() > 0);
         exp_rd = racc ? q[0] : '0;
         w_en = we; r_en = re; din = rnd[DW-1:0];
         tick();
         if (racc) void'(q.pop_front());
         if (wacc) q.push_back(rnd[DW-1:0]);
         checks++; if (cnt0 !== 4'(q.size()) || cnt1 !== 4'(q.size()) || cnt0 > 4'd8) begin errors++; $display("FAIL rand_cnt c%0d got %0d/%0d want %0d", c, cnt0, cnt1, q.size()); end
         checks++; if (dv0 !== racc) begin errors++; $display("FAIL rand_dv0 c%0d got %b want %b", c, dv0, racc); end
         if (racc) begin
            checks++; if (dout0 !== exp_rd) begin errors++; $display("FAIL rand_dout0 c%0d got %h want %h", c, dout0, exp_rd); end
         end
         checks++; if (dv1 !== (q.size() > 0)) begin errors++; $display("FAIL rand_dv1 c%0d got %b want %b", c, dv1, q.size() > 0); end
         if (q.size() > 0) begin
            checks++; if (dout1 !== q[0]) begin errors++; $display("FAIL rand_dout1 c%0d got %h want %h", c, dout1, q[0]); end
         end
      end
      idle();
   endtask

   initial begin
      rst_n = 1'b0; idle();
      test_reset();
      test_basic();
      test_full();
      test_showahead();
      test_flush_reset();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/triangle_fifo.md
# triangle_fifo

Parametrised synchronous FIFO that buffers screen-space triangles between the vertex/projection stage and the rasteriser. It contains its own storage, pointer management, occupancy count, an almost-full threshold, sticky overflow/underflow flags, a synchronous flush, and a selectable read mode: registered read or show-ahead (first-word-fall-through). Capacity and entry width are generics, so the same block serves the triangle queue and any other per-primitive queue in the pipeline.

## Interface
Parameters:
- COORD_W, 10, width of one screen coordinate
- COORDS, 6, coordinates per entry (x0,y0,x1,y1,x2,y2); DATA_W = COORD_W*COORDS
- DEPTH, 128, total entry capacity; power of two, ≥ 4; AW = $clog2(DEPTH)
- AF_LEVEL, DEPTH-4, almost_full asserts when count ≥ AF_LEVEL; 1 ≤ AF_LEVEL ≤ DEPTH
- SHOWAHEAD, 0, 0 = registered read, 1 = first-word-fall-through

Ports:
- Clk  in  1  rising-edge clock
- Reset_n  in  1  synchronous, active-low reset
- flush  in  1  synchronous clear of contents and flags
- w_en  in  1  write request
- data_in  in  DATA_W  entry to write
- full  out  1  count == DEPTH
- almost_full  out  1  count ≥ AF_LEVEL
- r_en  in  1  read request (mode 0) / pop acknowledge (mode 1)
- data_out  out  DATA_W  read data
- data_valid  out  1  data_out holds a valid entry (see Timing)
- empty  out  1  count == 0
- count  out  AW+1  entries held
- overflow  out  1  sticky: write attempted while full
- underflow  out  1  sticky: read attempted while empty

## Operation
- Write accepted iff w_en && !full; entry stored at wr_ptr, wr_ptr++ (AW bits, wraps modulo DEPTH).
- Read accepted iff r_en && !empty; rd_ptr++ (wraps).
- count: +1 on accepted write only, −1 on accepted read only, unchanged on both or neither. full/empty/almost_full are derived from the registered count.
- Simultaneous read and write when full: read accepted, write rejected, overflow set. When empty: write accepted, read rejected, underflow set. No bypass in mode 0.
- Rejected write: no state change except overflow ← 1. Rejected read: no state change except underflow ← 1; data_out holds its value.
- flush (Reset_n high): pointers, count, data_valid, overflow, underflow ← 0; accesses in the same cycle are ignored. Memory contents are not cleared.
- Reset_n low takes priority over flush and over all accesses. Reset in mid-stream discards every entry, including the one held in data_out.
- Mode 1: one output register holds the head entry and counts toward count. Capacity stays DEPTH. When the output register is empty or being popped, the next entry is prefetched from RAM, or bypassed from data_in if the RAM is empty.

## Timing
- Reset values: data_out 0, data_valid 0, empty 1, full 0, almost_full 0 (1 if AF_LEVEL ≤ 0, which is illegal), count 0, overflow 0, underflow 0.
- Mode 0: read accepted at edge N → data_out valid and data_valid = 1 for exactly the cycle after edge N. data_out holds otherwise, and data_valid = 0.
- Mode 1: data_valid = !empty. data_out is the head whenever data_valid = 1. A write into an empty FIFO at edge N → data_valid = 1 after edge N. A pop at edge N presents the next entry after edge N, with no bubble while entries remain.
- full, empty, almost_full and count update on the same edge as the access that changes them. No combinational path from inputs to outputs.

## Structure
- Package triangle_pkg: COORD_W and COORDS defaults, typedef triangle_t (packed array of COORDS × COORD_W). This package is shared with the projection and rasteriser stages.
- Sub-module triangle_fifo_mem: simple dual-port RAM with one write port and one registered read port, parameters DATA_W and DEPTH, inferable as block RAM. Pointer logic, count and flags, and the mode-1 prefetch/output register live in triangle_fifo.

## Test plan
- Reset, then 4 writes (0x1…0x4), then 4 reads in mode 0 → data_out 0x1–0x4 in order, each one cycle after its read. count 4→0; empty = 1 at end; underflow = 0.
- DEPTH = 8, AF_LEVEL = 6: 8 writes → almost_full rises after the 6th, full after the 8th. A 9th write → overflow = 1, count stays 8, contents unchanged on read-back.
- With count = 8 (full), simultaneous w_en + r_en → read returns the oldest entry, write dropped, count = 7, overflow = 1. With count = 0, simultaneous w_en + r_en → count = 1, underflow = 1.
- Wrap-around: 1000 random push/pop cycles against a reference queue model with DEPTH = 8 → every data_out matches and count never leaves 0..8.
- Mode 1: write 0xA at edge N → data_valid = 1 and data_out = 0xA after edge N. Push 0xB and 0xC, then pop every cycle → 0xA, 0xB, 0xC on consecutive cycles, then empty = 1.
- flush with count = 5 and overflow = 1, w_en asserted in the same cycle → count = 0, empty = 1, overflow = 0, data_valid = 0, and the write is ignored. Repeat with Reset_n low in mid-burst → all outputs return to their reset values.
